instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction-memory writer for the pipelined MIPS core: the inverse of the fetch-stage decode. It accepts decoded instruction fields (op, func, rs, rt, rd, valC) over a valid/ready handshake, packs them into a 32-bit MIPS word, and writes the words at consecutive addresses into the instruction memory write port, holding each write until the memory acknowledges it. Test benches and the program loader use it to build a program image from the same field view the fetch stage produces.

## Interface
- `ADDR_W`, 4: memory word-address width; capacity is 2^ADDR_W words (16 by default).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept a bundle this cycle.
- `in_op`  in  6  opcode.
- `in_func`  in  6  R-type function code.
- `in_rs` / `in_rt` / `in_rd`  in  5 each  register fields.
- `in_valC`  in  32  immediate or jump target, already sign-/zero-extended as decode produces it.
- `in_clear`  in  1  synchronous restart: address, count, full and error return to 0.
- `wr_en`  out  1  memory write request.
- `wr_addr`  out  ADDR_W  word address.
- `wr_data`  out  32  encoded instruction.
- `wr_ack`  in  1  memory accepted the write this cycle.
- `count`  out  ADDR_W+1  words written since reset or clear.
- `full`  out  1  count == 2^ADDR_W.
- `err`  out  1  sticky: an unsupported or unencodable bundle was seen.
- `err_op`  out  6  opcode of the first erroneous bundle.

## Operation
- Encoding:
  - R-type (op 000000): {op, rs, rt, rd, 5'b0, func}.
  - I-type (LW 100011, SW 101011, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110): {op, rs, rt, valC[15:0]}. Legal only if valC[31:16] == {16{valC[15]}}.
  - J (000010): {op, valC[25:0]}. Legal only if valC[31:26] == 0.
  - For I-type and J, func/rd (and rs/rt for J) are ignored.
- Any other op, or an illegal valC, is an error bundle. It is still accepted, but nothing is written and count does not change. Sets err; err_op is captured only if err was 0.
- FSM states: IDLE, WRITE, FULL.
  - IDLE: `in_ready = ~in_clear`. A legal handshake registers wr_data and moves to WRITE. An error handshake stays in IDLE.
  - WRITE: `wr_en = 1`; wr_addr and wr_data stay stable. On wr_ack: wr_addr++, count++, then go to FULL if the new count is 2^ADDR_W, else IDLE.
  - FULL: in_ready = 0, full = 1; only in_clear or rst leaves this state.
- `in_clear` has priority in every state. It goes to IDLE with wr_addr = 0, count = 0, err = 0, err_op = 0. A pending write is abandoned: wr_en drops on the next cycle, even if wr_ack is high in the same cycle.
- `in_ready` is low in WRITE and FULL, so no bundle is accepted while a write is outstanding.
- wr_addr equals count[ADDR_W-1:0]. On reaching full, wr_addr wraps to 0 but is not driven with wr_en.

## Timing
- All outputs are registered except in_ready, which is decoded from state and in_clear.
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, count 0, full 0, err 0, err_op 0. in_ready is 1 while rst is low and in_clear is low.
- Reset takes effect immediately, including mid-WRITE: wr_en drops asynchronously.
- Write latency:
  - Bundle accepted at edge N gives wr_en = 1 from edge N to the edge M where wr_ack is sampled.
  - wr_en = 0 and in_ready = 1 (unless full) after edge M.
  - Minimum 2 cycles per word when wr_ack is tied high.
- wr_ack while wr_en = 0 is ignored.
- An error bundle costs 1 cycle; in_ready stays high.

## Test plan
- R-type add: op 0, rs 1, rt 2, rd 3, func 0x20, wr_ack tied 1 -> one wr_en pulse at wr_addr 0 with wr_data 0x00221820; then count 1.
- ADDI rs 1, rt 2, valC 0xFFFFFFFC, then J valC 0x00000010 -> writes 0x2022FFFC at addr 0, then 0x08000010 at addr 1.
- Error cases:
  - op 0x3F -> err 1, err_op 0x3F, no wr_en, count unchanged.
  - Then ADDI with valC 0x00018000 -> err_op stays 0x3F.
  - in_clear -> err 0.
- wr_ack withheld for 3 cycles -> wr_en, wr_addr and wr_data stable for all 4 cycles and in_ready 0; count increments only after the ack.
- 16 legal bundles -> full 1, count 16, in_ready 0, a 17th in_valid is ignored; in_clear -> count 0, full 0, next write goes to addr 0.
- rst asserted mid-WRITE -> wr_en 0 immediately, all outputs at their reset values; in_clear asserted with wr_ack in WRITE -> count 0, no further wr_en.

Source files
------------

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Field-bundle handshake plus instruction-memory write port
//            between a field source / memory and the instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [5:0]        in_func;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [31:0]       in_valC;
  logic              in_clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ack;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic [5:0]        err_op;

  // Source/memory side: drives the field bundle, clear and write acknowledge.
  modport master (
    output in_valid, in_op, in_func, in_rs, in_rt, in_rd, in_valC, in_clear, wr_ack,
    input  in_ready, wr_en, wr_addr, wr_data, count, full, err, err_op
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_func, in_rs, in_rt, in_rd, in_valC, in_clear, wr_ack,
    output in_ready, wr_en, wr_addr, wr_data, count, full, err, err_op
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs decoded MIPS fields into 32-bit words and writes them to
//            consecutive instruction-memory addresses, holding each write
//            until the memory acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W = 4
) (
  input  wire                    clk,
  input  wire                    rst,
  instr_encoder_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [5:0]        err_op_q, err_op_d;

  logic              w_is_r, w_is_i, w_is_j;
  logic              w_legal;
  logic [31:0]       w_word;
  logic              w_accept;
  logic [ADDR_W:0]   w_count_inc;

  // Classify the opcode, check the immediate fits, and build the word.
  always_comb begin
    w_is_r = (bus.in_op == 6'b000000);
    w_is_j = (bus.in_op == 6'b000010);
    w_is_i = 1'b0;
    case (bus.in_op)
      6'b100011, 6'b101011, 6'b001000, 6'b001010,
      6'b001100, 6'b001101, 6'b001110: w_is_i = 1'b1;
      default:                         w_is_i = 1'b0;
    endcase
    w_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_valC[15:0]};
    if (w_is_r) begin
      w_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_func};
    end else if (w_is_j) begin
      w_word = {bus.in_op, bus.in_valC[25:0]};
    end
    w_legal = w_is_r
            | (w_is_i & (bus.in_valC[31:16] == {16{bus.in_valC[15]}}))
            | (w_is_j & (bus.in_valC[31:26] == 6'b000000));
  end

  // Only IDLE takes bundles, and never while a clear is being applied.
  assign bus.in_ready = (state_q == IDLE) & ~bus.in_clear;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_count_inc  = count_q + ONE_COUNT;

  // Next-state and registered-output logic; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    full_d    = full_q;
    err_d     = err_q;
    err_op_d  = err_op_q;
    if (bus.in_clear) begin
      // Abandons any pending write even if it is acked this cycle.
      state_d   = IDLE;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      count_d   = '0;
      full_d    = 1'b0;
      err_d     = 1'b0;
      err_op_d  = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              wr_data_d = w_word;
              wr_en_d   = 1'b1;
              state_d   = WRITE;
            end else begin
              err_d = 1'b1;
              if (!err_q) err_op_d = bus.in_op;
            end
          end
        end
        WRITE: begin
          if (bus.wr_ack) begin
            wr_en_d   = 1'b0;
            count_d   = w_count_inc;
            // Wraps to 0 when the memory fills; no write is issued there.
            wr_addr_d = w_count_inc[ADDR_W-1:0];
            if (w_count_inc == FULL_COUNT) begin
              state_d = FULL;
              full_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = IDLE;
          wr_en_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'd0;
      count_q   <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      err_op_q  <= 6'd0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      full_q    <= full_d;
      err_q     <= err_d;
      err_op_q  <= err_op_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.count   = count_q;
  assign bus.full    = full_q;
  assign bus.err     = err_q;
  assign bus.err_op  = err_op_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Self-checking bench for instr_encoder with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t        exp_q[$];
  logic [3:0] exp_addr = 4'd0;

  instr_encoder_if #(.ADDR_W(4)) bus ();

  instr_encoder #(.ADDR_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference encoder: returns {legal, word}.
  function automatic logic [32:0] model(input logic [5:0] op, input logic [5:0] func,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [31:0] v);
    logic sx_ok;
    sx_ok = (v[31:16] == 16'h0000 && !v[15]) || (v[31:16] == 16'hFFFF && v[15]);
    case (op)
      6'h00: return {1'b1, op, rs, rt, rd, 5'd0, func};
      6'h02: return {(v[31:26] == 6'd0), op, v[25:0]};
      6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: return {sx_ok, op, rs, rt, v[15:0]};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  // Scoreboard: every acknowledged write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.wr_en && bus.wr_ack && !bus.in_clear) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.wr_en && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("write_timeout", 64'd0, 64'd1);
  endtask

  // Present one bundle for one accepting edge; push the expected write if legal.
  task automatic send(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] v,
                      input logic legal, input logic [31:0] word);
    wait_ready();
    bus.in_op = op; bus.in_func = func; bus.in_rs = rs;
    bus.in_rt = rt; bus.in_rd = rd; bus.in_valC = v;
    bus.in_valid = 1'b1;
    if (legal) begin
      exp_q.push_back('{addr: exp_addr, data: word});
      exp_addr++;
    end
    tick();
    bus.in_valid = 1'b0;
    check("accept_wr_en", 64'(bus.wr_en), 64'(legal));
  endtask

  task automatic clear();
    bus.in_clear = 1'b1;
    tick();
    bus.in_clear = 1'b0;
    exp_addr = 4'd0;
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] d0;
    bus.in_valid = 1'b0; bus.in_op = 6'd0; bus.in_func = 6'd0; bus.in_rs = 5'd0;
    bus.in_rt = 5'd0; bus.in_rd = 5'd0; bus.in_valC = 32'd0; bus.in_clear = 1'b0;
    bus.wr_ack = 1'b0;

    // Reset values.
    #1;
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_err_op", 64'(bus.err_op), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // R-type add, ack tied high: two cycles per word.
    bus.wr_ack = 1'b1;
    send(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h00221820);
    check("r_wr_data", 64'(bus.wr_data), 64'h00221820);
    tick();
    check("r_wr_en_drop", 64'(bus.wr_en), 64'd0);
    check("r_in_ready", 64'(bus.in_ready), 64'd1);
    check("r_count", 64'(bus.count), 64'd1);

    // ADDI with negative immediate, then J, from a cleared image.
    clear();
    send(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b1, 32'h2022FFFC);
    wait_done();
    send(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 32'h00000010, 1'b1, 32'h08000010);
    wait_done();
    check("ij_count", 64'(bus.count), 64'd2);

    // Error bundles.
    send(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    check("err_set", 64'(bus.err), 64'd1);
    check("err_op", 64'(bus.err_op), 64'h3F);
    check("err_count", 64'(bus.count), 64'd2);
    check("err_in_ready", 64'(bus.in_ready), 64'd1);
    send(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'h00018000, 1'b0, 32'd0);
    check("err_op_sticky", 64'(bus.err_op), 64'h3F);
    check("err_count2", 64'(bus.count), 64'd2);
    clear();
    check("err_cleared", 64'(bus.err), 64'd0);
    check("err_op_cleared", 64'(bus.err_op), 64'd0);

    // Ack withheld for three cycles.
    bus.wr_ack = 1'b0;
    m = model(6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 32'h00001234);
    send(6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 32'h00001234, m[32], m[31:0]);
    d0 = bus.wr_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_wr_en", 64'(bus.wr_en), 64'd1);
      check("hold_wr_addr", 64'(bus.wr_addr), 64'd0);
      check("hold_wr_data", 64'(bus.wr_data), 64'(d0));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_count", 64'(bus.count), 64'd0);
    end
    bus.wr_ack = 1'b1;
    tick();
    check("hold_count_after", 64'(bus.count), 64'd1);
    check("hold_wr_en_after", 64'(bus.wr_en), 64'd0);

    // Fill the memory with 16 words.
    clear();
    for (int i = 0; i < 16; i++) begin
      logic [5:0]  op;
      logic [31:0] v;
      logic [4:0]  rs, rt, rd;
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      case (i % 4)
        0: begin op = 6'h00; v = 32'd0; end
        1: begin op = 6'h08; v = -32'(i); end
        2: begin op = 6'h02; v = 32'(i * 4); end
        default: begin op = 6'h0D; v = 32'(i * 32'h111); end
      endcase
      m = model(op, 6'(i + 32), rs, rt, rd, v);
      send(op, 6'(i + 32), rs, rt, rd, v, m[32], m[31:0]);
      wait_done();
    end
    check("full_flag", 64'(bus.full), 64'd1);
    check("full_count", 64'(bus.count), 64'd16);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_wr_addr", 64'(bus.wr_addr), 64'd0);
    bus.in_op = 6'h00; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.in_valid = 1'b0;
    check("full_ignore_wr_en", 64'(bus.wr_en), 64'd0);
    check("full_ignore_count", 64'(bus.count), 64'd16);
    clear();
    check("clr_count", 64'(bus.count), 64'd0);
    check("clr_full", 64'(bus.full), 64'd0);
    send(6'h00, 6'h25, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1, 32'h00E84825);
    wait_done();

    // Asynchronous reset mid-write.
    clear();
    bus.wr_ack = 1'b0;
    send(6'h23, 6'h00, 5'd4, 5'd5, 5'd0, 32'h00000008, 1'b1, 32'h8C850008);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("arst_wr_en", 64'(bus.wr_en), 64'd0);
    check("arst_wr_data", 64'(bus.wr_data), 64'd0);
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_wr_addr", 64'(bus.wr_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_addr = 4'd0;
    tick();

    // Clear with a simultaneous ack abandons the write.
    send(6'h2B, 6'h00, 5'd4, 5'd5, 5'd0, 32'h0000000C, 1'b1, 32'hAC85000C);
    void'(exp_q.pop_back());
    bus.wr_ack = 1'b1;
    clear();
    check("clr_ack_count", 64'(bus.count), 64'd0);
    check("clr_ack_wr_en", 64'(bus.wr_en), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_ack_idle", 64'(bus.wr_en), 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
